pwm_decoder: RTL and testbench
==============================

# pwm_decoder

Receive-side counterpart of the 5-step PWM generator. Samples a single PWM line, measures its duty cycle over a fixed window of whole PWM periods, and recovers the generator's control code (E, X, Y). It also reports whether the measurement was an exact step and whether the decoded code has been stable. It sits on the far end of any PWM link driven by the generator, for loop-back checking and for remote control decode.

## Interface
- FRAMES, 8: PWM periods per measurement window. Must be ≥ 2.
- PERIOD, 4 (localparam, fixed): clocks per PWM period. Window length W = PERIOD*FRAMES (32 at default).
- Clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- In  input  1  PWM line; may be asynchronous to Clk.
- E  output  1  decoded enable; 0 means duty 0%.
- X  output  1  decoded select MSB.
- Y  output  1  decoded select LSB.
- Valid  output  1  one-cycle strobe: E/X/Y/Exact updated this cycle.
- Exact  output  1  last window's high count equalled an exact step value.
- Locked  output  1  two or more consecutive exact windows decoded to the same code.

## Operation
- Input path: 2-flop synchronizer on In, giving s. Only s is used downstream.
- Window counter wcnt runs 0..W-1, free-running, and wraps to 0.
- High counter hcnt accumulates s each cycle and is cleared at each window boundary. Width is clog2(W+1) bits (6 at default), so it never overflows.
- Final count at window end: C = hcnt + s, sampled on the cycle wcnt == W-1.
- Step k (0..4) is the nearest quarter: k = number of thresholds j in 0..3 with 2C ≥ (2j+1)*FRAMES. Ties round up.
- Code map from step to {E,X,Y}:
  - k0 (0%) → 0,0,0
  - k1 (25%) → 1,0,0
  - k2 (50%) → 1,0,1
  - k3 (75%) → 1,1,0
  - k4 (100%) → 1,1,1
- Exact = (C == k*FRAMES).
- Window phase relative to the PWM period is irrelevant. Any W consecutive samples of a steady waveform contain exactly k*FRAMES highs.
- Lock state machine (states UNLOCKED, CANDIDATE, LOCKED), evaluated at each window end:
  - Non-exact window → UNLOCKED.
  - Exact window from UNLOCKED → CANDIDATE; the code is remembered.
  - Exact window from CANDIDATE or LOCKED with the same code → LOCKED.
  - Exact window from CANDIDATE or LOCKED with a different code → CANDIDATE, with the new code remembered.
  - Locked = (state == LOCKED).
- E/X/Y/Exact hold their values between windows. They are updated on every window end, including non-exact windows.

## Timing
- Reset (synchronous, while reset = 1 at a rising edge): sync flops, wcnt, hcnt, E, X, Y, Valid, Exact, Locked all go to 0; lock state goes to UNLOCKED.
- Reset mid-window discards the partial window. No Valid is produced for it.
- First window starts at the first rising edge with reset = 0 (wcnt = 0 sampled there).
- Valid is high for exactly one cycle, during the cycle after the edge where wcnt == W-1. E/X/Y/Exact/Locked change on that same edge.
- Valid repeats every W cycles. First Valid after reset release occurs W cycles later.
- The first window after reset includes 2 synchronizer-zero samples. An inexact first result is permitted.
- Latency from an In duty change to a correct decode: 2 cycles (sync), plus up to 2W cycles (one mixed window, then one clean window). Locked needs one further clean window.
- Simultaneous reset and window end: reset wins. No Valid; outputs go to 0.

## Test plan
- Reset: hold reset for 5 cycles with In = 1 → all outputs 0 during and on the first cycle after release. No Valid until 32 cycles after release.
- Steady 50% (generator E=1, XY=01, FRAMES=8) → from the second window on: C=16, E/X/Y = 1/0/1, Exact=1, Valid every 32 cycles. Locked=1 from the third Valid.
- Constant lines: In = 0 → E/X/Y = 0/0/0 with Exact=1. In = 1 → 1/1/1 with Exact=1. Locked follows on the next window.
- Switch from 25% to 75% mid-window → the mixed window gives some C between 8 and 24, with Locked dropping if inexact. Next window: C=24, code 1/1/0, Exact=1 (CANDIDATE). Following window: Locked=1.
- Glitch: a 50% stream with one extra high sample in one window → C=17, code 1/0/1, Exact=0, Locked=0. Next clean window: Exact=1, Locked still 0. The window after that: Locked=1.
- Reset pulse of 1 cycle at wcnt=20 → no Valid for that window. Next Valid occurs 32 cycles after the reset edge releases.

Source files
------------

// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Receive side of the 5-step PWM link. Synchronises the PWM line, counts
//   high samples over a fixed window of whole PWM periods, and maps the
//   count to the nearest quarter-duty step and its control code {E,X,Y}.
//   A small lock machine reports when consecutive exact windows agree.
//
//   State table (lock machine, advanced only at window end)
//     state     | meaning
//     UNLOCKED  | last window was not an exact step (or just out of reset)
//     CANDIDATE | one exact window seen; its code is held in code_mem
//     LOCKED    | two or more consecutive exact windows with the same code
//
// Ports
//   Clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   In      in   PWM line, may be asynchronous to Clk
//   E,X,Y   out  decoded control code, held between windows
//   Valid   out  one-cycle strobe when E/X/Y/Exact/Locked were updated
//   Exact   out  last window's high count hit an exact step value
//   Locked  out  lock machine is in LOCKED
module pwm_decoder #(
    parameter int FRAMES = 8
) (
    input  logic Clk,
    input  logic reset,
    input  logic In,
    output logic E,
    output logic X,
    output logic Y,
    output logic Valid,
    output logic Exact,
    output logic Locked
);

    localparam int PERIOD = 4;
    localparam int W      = PERIOD * FRAMES;
    localparam int WW     = $clog2(W);
    localparam int HW     = $clog2(W + 1);
    localparam int TW     = HW + 1;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2
    } lock_state_t;

    lock_state_t     state;
    logic [2:0]      code_mem;
    logic            s1;
    logic            s2;
    logic [WW-1:0]   wcnt;
    logic [HW-1:0]   hcnt;

    logic            win_end;
    logic [HW-1:0]   c_fin;
    logic [TW-1:0]   c_twice;
    logic [2:0]      k;
    logic [HW-1:0]   step_val;
    logic [2:0]      code;
    logic            exact_now;

    assign win_end = (wcnt == WW'(W - 1));
    // The sample taken on the last cycle of the window belongs to it.
    assign c_fin   = hcnt + HW'(s2);
    assign c_twice = {c_fin, 1'b0};

    // Nearest quarter with ties rounding up: count the midpoints 2C reaches.
    always_comb begin
        k = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (c_twice >= TW'((2 * j + 1) * FRAMES)) begin
                k = k + 3'd1;
            end
        end
    end

    always_comb begin
        step_val = '0;
        code     = 3'b000;
        case (k)
            3'd0: begin step_val = '0;               code = 3'b000; end
            3'd1: begin step_val = HW'(FRAMES);      code = 3'b100; end
            3'd2: begin step_val = HW'(2 * FRAMES);  code = 3'b101; end
            3'd3: begin step_val = HW'(3 * FRAMES);  code = 3'b110; end
            default: begin step_val = HW'(4 * FRAMES); code = 3'b111; end
        endcase
    end

    assign exact_now = (c_fin == step_val);

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            wcnt     <= '0;
            hcnt     <= '0;
            E        <= 1'b0;
            X        <= 1'b0;
            Y        <= 1'b0;
            Valid    <= 1'b0;
            Exact    <= 1'b0;
            Locked   <= 1'b0;
            state    <= UNLOCKED;
            code_mem <= 3'b000;
        end else begin
            s1    <= In;
            s2    <= s1;
            Valid <= win_end;
            if (win_end) begin
                wcnt      <= '0;
                hcnt      <= '0;
                {E, X, Y} <= code;
                Exact     <= exact_now;
                if (!exact_now) begin
                    state  <= UNLOCKED;
                    Locked <= 1'b0;
                end else if (state == UNLOCKED || code != code_mem) begin
                    state    <= CANDIDATE;
                    code_mem <= code;
                    Locked   <= 1'b0;
                end else begin
                    state  <= LOCKED;
                    Locked <= 1'b1;
                end
            end else begin
                wcnt <= wcnt + WW'(1);
                hcnt <= hcnt + HW'(s2);
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Drives pwm_decoder with directed and random PWM streams, glitches and
//   reset pulses, and compares every output each cycle against a window-level
//   reference model (high count per window -> nearest quarter -> code, and a
//   run-length count of consecutive identical exact codes for lock).
module tb_pwm_decoder;

    localparam int F = 8;
    localparam int W = 4 * F;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic In = 1'b0;
    logic E, X, Y, Valid, Exact, Locked;

    always #5 Clk = ~Clk;

    pwm_decoder #(.FRAMES(F)) dut (
        .Clk    (Clk),
        .reset  (reset),
        .In     (In),
        .E      (E),
        .X      (X),
        .Y      (Y),
        .Valid  (Valid),
        .Exact  (Exact),
        .Locked (Locked)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus state
    int   duty      = 0;
    int   ph        = 0;
    bit   force_hi  = 1'b0;
    logic rst_drive = 1'b1;

    // reference model state
    bit         hist[$];
    int         n      = 0;
    int         acc    = 0;
    int         streak = 0;
    logic [2:0] last_code = 3'b000;
    logic [2:0] code_tbl[5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    logic       m_valid = 1'b0, m_exact = 1'b0, m_locked = 1'b0;
    logic [2:0] m_code = 3'b000;

    task automatic model_step(input logic r, input logic i);
        int c;
        int k;
        bit s;
        if (r) begin
            hist.delete();
            n = 0; acc = 0; streak = 0; last_code = 3'b000;
            m_valid = 0; m_exact = 0; m_locked = 0; m_code = 3'b000;
        end else begin
            hist.push_back(i);
            s = (n >= 2) ? hist[n - 2] : 1'b0;
            acc += int'(s);
            m_valid = 0;
            if (n % W == W - 1) begin
                c   = acc;
                acc = 0;
                k   = (2 * c + F) / (2 * F);
                if (k > 4) k = 4;
                m_code  = code_tbl[k];
                m_exact = (c == k * F);
                if (m_exact) begin
                    streak    = (streak > 0 && m_code == last_code) ? streak + 1 : 1;
                    last_code = m_code;
                end else begin
                    streak = 0;
                end
                m_locked = (streak >= 2);
                m_valid  = 1;
            end
            n++;
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        In       = force_hi ? 1'b1 : logic'(ph < duty);
        force_hi = 1'b0;
        reset    = rst_drive;
        ph       = (ph + 1) % 4;
        @(posedge Clk);
        model_step(reset, In);
        #1;
        chk("valid",  Valid,     m_valid);
        chk("exy",    {E, X, Y}, m_code);
        chk("exact",  Exact,     m_exact);
        chk("locked", Locked,    m_locked);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic wait_valid(input string tag);
        int cnt = 0;
        bit seen = 1'b0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            tick();
            if (Valid === 1'b1) begin
                seen = 1'b1;
                cnt  = c;
            end
        end
        chk(tag, cnt, W);
    endtask

    initial begin
        // reset held with the line high: outputs must stay 0
        duty = 4;
        rst_drive = 1'b1;
        run(5);
        rst_drive = 1'b0;
        wait_valid("first_valid");

        // steady 50%
        duty = 2;
        run(4 * W);
        chk("d50_exy", {E, X, Y}, 3'b101);
        chk("d50_exact", Exact, 1);
        chk("d50_lock", Locked, 1);

        // constant lines
        duty = 0;
        run(4 * W);
        chk("c0_exy", {E, X, Y}, 3'b000);
        chk("c0_exact", Exact, 1);
        chk("c0_lock", Locked, 1);
        duty = 4;
        run(4 * W);
        chk("c1_exy", {E, X, Y}, 3'b111);
        chk("c1_exact", Exact, 1);
        chk("c1_lock", Locked, 1);

        // 25% then 75% switched mid-window
        duty = 1;
        run(4 * W + 13);
        duty = 3;
        run(4 * W);
        chk("d75_exy", {E, X, Y}, 3'b110);
        chk("d75_lock", Locked, 1);

        // single extra high sample in a 50% stream
        duty = 2;
        run(4 * W);
        while (ph != 2) tick();
        force_hi = 1'b1;
        run(3 * W);
        chk("glitch_lock", Locked, 1);

        // one-cycle reset pulse at wcnt = 20
        while (n % W != 20) tick();
        rst_drive = 1'b1;
        tick();
        rst_drive = 1'b0;
        wait_valid("rst_pulse_valid");

        // random segments with glitches, phase jumps and resets
        for (int seg = 0; seg < 30; seg++) begin
            int len;
            duty = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) ph = $urandom_range(0, 3);
            len = $urandom_range(20, 150);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 60) == 0) force_hi = 1'b1;
                tick();
            end
            if ($urandom_range(0, 4) == 0) begin
                rst_drive = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst_drive = 1'b0;
            end
        end
        run(3 * W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
